// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   rx_state_t    : receiver framing FSM states
//   DATA_BITS     : data bits per character (8N1 framing)
//   clks_per_bit(): system clocks per line bit (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented combinationally on
// `head`; a push into an empty FIFO becomes visible the following cycle (no
// bypass). A push is accepted when not full, or when a pop happens in the same
// cycle. A pop on an empty FIFO is ignored.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   push/push_data : write request and data
//   pop            : read request (head is consumed at the clock edge)
//   head           : current head entry
//   count          : occupancy, 0..DEPTH
//   full, empty    : occupancy status
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity, and
  // leaving the array unreset lets it map onto plain RAM/register-file cells.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver with a show-ahead receive FIFO and sticky status flags.
// Ports:
//   clock, reset_n  : system clock, asynchronous active-low reset
//   uart_rx         : raw serial line (idle high, asynchronous)
//   rx_data         : byte at the FIFO head (0 while rx_valid = 0)
//   rx_valid        : FIFO not empty
//   rx_ready        : consumer accepts the head byte when rx_valid is high
//   rx_count        : FIFO occupancy
//   framing_error   : sticky, a stop bit was sampled low
//   overrun         : sticky, a good byte was dropped on a full FIFO
//   clear_errors    : one-cycle pulse clearing both sticky flags (set wins)
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ   = 27000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          uart_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          framing_error,
  output logic                          overrun,
  input  logic                          clear_errors
);

  localparam int CPB   = clks_per_bit(CLOCK_HZ, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] sh;

  logic                 stop_sample;
  logic                 push_req;
  logic                 pop;
  logic [7:0]           fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Two-flop synchroniser; flops reset to the idle (high) line level so a
  // reset never looks like a start bit.
  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its source, independent of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  // Framing FSM. START waits half a bit to land mid-bit; every later sample
  // is a full bit period after the previous one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            if (rx_s) begin
              state <= IDLE;          // line came back high: glitch
            end else begin
              cnt   <= '0;
              idx   <= '0;
              state <= DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            sh  <= {rx_s, sh[DATA_BITS-1:1]};   // LSB first
            idx <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            // A low stop bit may be a break; wait for the line to recover.
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The push is issued during the stop-sample cycle so the byte is in the
  // FIFO (and visible) on the cycle right after the sample.
  assign stop_sample = (state == STOP) && (cnt == BIT_LAST);
  assign push_req    = stop_sample && rx_s;
  assign pop         = rx_valid && rx_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (stop_sample && !rx_s)             framing_error <= 1'b1;
      else if (clear_errors)                framing_error <= 1'b0;

      if (push_req && fifo_full && !pop)    overrun <= 1'b1;
      else if (clear_errors)                overrun <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (sh),
    .pop       (pop),
    .head      (fifo_head),
    .count     (rx_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  // Gate the head so the unreset storage never leaks onto rx_data.
  assign rx_data  = rx_valid ? fifo_head : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed stimulus at 234 clocks/bit. Expected received bytes go into a
// scoreboard queue as they are sent; a negedge monitor compares every byte the
// DUT hands over (rx_valid && rx_ready) against the queue head.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB = 234;
  // Stop-bit sample edge counted from the start-bit drive edge:
  // 2 sync clocks + 1 detect clock + half bit (117) + 9 full bits.
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       framing_error;
  logic       overrun;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  uart_rx_fifo dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_count      (rx_count),
    .framing_error (framing_error),
    .overrun       (overrun),
    .clear_errors  (clear_errors)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handed-over byte must match the queue head.
  always @(negedge clock) begin
    if (reset_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got 0x%0h expected no byte", rx_data);
      end else begin
        check("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    tick(1);
    clear_errors = 1'b0;
  endtask

  // One 8N1 frame, one iteration per clock. Optional pop exactly in the
  // stop-sample cycle and optional check of push latency.
  task automatic send_byte(input logic [7:0] b, input logic stop_val,
                           input logic pop_at_stop, input logic chk_lat);
    for (int c = 0; c < 10 * CPB; c++) begin
      int bitn;
      bitn = c / CPB;
      if (bitn == 0)      uart_rx = 1'b0;
      else if (bitn < 9)  uart_rx = b[bitn-1];
      else                uart_rx = stop_val;
      if (pop_at_stop) rx_ready = (c == STOP_EDGE - 1);
      if (chk_lat && c == STOP_EDGE - 1) check("lat_valid_before", {31'h0, rx_valid}, 32'h0);
      if (chk_lat && c == STOP_EDGE) begin
        check("lat_valid_after", {31'h0, rx_valid}, 32'h1);
        check("lat_data", {24'h0, rx_data}, {24'h0, b});
        check("lat_count", {28'h0, rx_count}, 32'h1);
      end
      tick(1);
    end
    if (pop_at_stop) rx_ready = 1'b0;
  endtask

  initial begin
    // Reset values
    tick(3);
    check("rst_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_count", {28'h0, rx_count}, 32'h0);
    check("rst_data", {24'h0, rx_data}, 32'h0);
    check("rst_fe", {31'h0, framing_error}, 32'h0);
    check("rst_ov", {31'h0, overrun}, 32'h0);
    reset_n = 1'b1;
    tick(5);

    // Single byte with latency check, then pop
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    check("single_count", {28'h0, rx_count}, 32'h1);
    pop_one();
    check("single_valid_after_pop", {31'h0, rx_valid}, 32'h0);
    check("single_count_after_pop", {28'h0, rx_count}, 32'h0);

    // Glitch rejection
    uart_rx = 1'b0;
    tick(50);
    uart_rx = 1'b1;
    tick(400);
    check("glitch_count", {28'h0, rx_count}, 32'h0);
    check("glitch_fe", {31'h0, framing_error}, 32'h0);
    check("glitch_ov", {31'h0, overrun}, 32'h0);

    // Framing error, line held low afterwards
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
    check("fe_set", {31'h0, framing_error}, 32'h1);
    check("fe_count", {28'h0, rx_count}, 32'h0);
    tick(1000);
    check("fe_hold_count", {28'h0, rx_count}, 32'h0);
    uart_rx = 1'b1;
    tick(50);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0, 1'b0);
    check("fe_recover_data", {24'h0, rx_data}, 32'h55);
    check("fe_recover_count", {28'h0, rx_count}, 32'h1);
    pop_one();
    check("fe_still_set", {31'h0, framing_error}, 32'h1);
    pulse_clear();
    check("fe_cleared", {31'h0, framing_error}, 32'h0);

    // Overrun: nine bytes, no consumer; 0x08 is dropped
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    end
    check("ov_count", {28'h0, rx_count}, 32'h8);
    check("ov_set", {31'h0, overrun}, 32'h1);
    check("ov_head", {24'h0, rx_data}, 32'h00);
    check("ov_fe", {31'h0, framing_error}, 32'h0);
    pulse_clear();
    check("ov_cleared", {31'h0, overrun}, 32'h0);

    // Full FIFO: pop in the stop-sample cycle, push is accepted
    exp_q.push_back(8'h08);
    send_byte(8'h08, 1'b1, 1'b1, 1'b0);
    check("fullpp_count", {28'h0, rx_count}, 32'h8);
    check("fullpp_ov", {31'h0, overrun}, 32'h0);
    check("fullpp_head", {24'h0, rx_data}, 32'h01);
    for (int i = 0; i < 8; i++) pop_one();
    check("drain_count", {28'h0, rx_count}, 32'h0);
    check("drain_valid", {31'h0, rx_valid}, 32'h0);
    // Pop on an empty FIFO is ignored
    pop_one();
    check("empty_pop_count", {28'h0, rx_count}, 32'h0);

    // Async reset mid-frame with state to clear
    send_byte(8'h11, 1'b0, 1'b0, 1'b0);
    uart_rx = 1'b1;
    tick(50);
    send_byte(8'h77, 1'b1, 1'b0, 1'b0);
    check("pre_rst_count", {28'h0, rx_count}, 32'h1);
    check("pre_rst_fe", {31'h0, framing_error}, 32'h1);
    for (int c = 0; c < 5 * CPB + 100; c++) begin
      uart_rx = (c < CPB) ? 1'b0 : 1'b1;
      tick(1);
    end
    reset_n = 1'b0;
    #2;
    check("mid_rst_valid", {31'h0, rx_valid}, 32'h0);
    check("mid_rst_count", {28'h0, rx_count}, 32'h0);
    check("mid_rst_data", {24'h0, rx_data}, 32'h0);
    check("mid_rst_fe", {31'h0, framing_error}, 32'h0);
    check("mid_rst_ov", {31'h0, overrun}, 32'h0);
    uart_rx = 1'b1;
    tick(5);
    reset_n = 1'b1;
    tick(10);
    check("post_rst_count", {28'h0, rx_count}, 32'h0);
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, 1'b0, 1'b0);
    check("post_rst_data", {24'h0, rx_data}, 32'h12);
    check("post_rst_count1", {28'h0, rx_count}, 32'h1);
    check("post_rst_fe", {31'h0, framing_error}, 32'h0);
    check("post_rst_ov", {31'h0, overrun}, 32'h0);
    pop_one();
    tick(2);

    check("scoreboard_left", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver feeding the CPU core's receive path from the board `uart_rx` pin.
- Synchronises the asynchronous line, frames 8N1 characters by mid-bit sampling, and buffers received bytes in a small show-ahead FIFO.
- Presents the bytes to the core over a valid/ready byte stream.
- Sticky framing-error and overrun flags are exposed for the core's UART status register.

Parameters:
- CLOCK_HZ, 27000000, system clock frequency.
- BAUD_RATE, 115200, line rate. CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE (integer division; 234 at defaults).
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of 2 and ≥ 2.

Ports:
- clock  input  1  system clock, single domain.
- reset_n  input  1  asynchronous, active-low reset.
- uart_rx  input  1  raw serial line, idle high, asynchronous to clock.
- rx_data  output  8  byte at the FIFO head; valid only while rx_valid = 1.
- rx_valid  output  1  FIFO not empty.
- rx_ready  input  1  consumer pop; a byte is popped when rx_valid && rx_ready.
- rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- framing_error  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a good byte was dropped because the FIFO was full.
- clear_errors  input  1  single-cycle pulse that clears both sticky flags.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n). All state clears immediately on reset_n low.
  - Synchroniser flops reset to 1. FSM resets to IDLE; FIFO empties.
  - Output reset values: rx_valid=0, rx_count=0, framing_error=0, overrun=0. rx_data=0 (don't-care when rx_valid=0).
- Input: two-flop synchroniser. rx_s is the second flop and is the only version of the line the FSM uses.
- Bit counter: cnt, width $clog2(CLKS_PER_BIT). Bit index: idx, 3 bits. Shift register: sh, 8 bits, filled LSB first (shift right, new bit into sh[7]).
- FSM states:
  - IDLE: on rx_s=0, set cnt=0 and go to START.
  - START: count to CLKS_PER_BIT/2 - 1 (116 at defaults), then sample rx_s.
    - rx_s=1: glitch, return to IDLE.
    - rx_s=0: set cnt=0, idx=0, go to DATA.
  - DATA: every CLKS_PER_BIT cycles (cnt wraps at CLKS_PER_BIT-1), shift rx_s into sh. After idx=7 is sampled, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s=1 and FIFO can accept: push sh. Go to IDLE.
    - rx_s=1 and FIFO cannot accept: set overrun, drop the byte. Go to IDLE.
    - rx_s=0: set framing_error, discard the byte. Go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break or stuck-low line from re-triggering starts.
- Latency:
  - Synchroniser: line edge to rx_s is 2 clocks.
  - Push: the byte is visible on rx_data with rx_valid=1 the cycle after the stop-bit sample.
- FIFO:
  - Show-ahead: rx_data is combinationally the head entry.
  - Pointers wrap modulo FIFO_DEPTH; rx_count tracks occupancy, 0..FIFO_DEPTH.
  - Push is accepted when !full, or when a pop occurs in the same cycle.
  - When full with simultaneous push and pop, both are performed and the count is unchanged.
  - When empty, a push with no concurrent pop is visible the next cycle; an empty FIFO never bypasses.
  - A pop while rx_valid=0 is ignored.
- Sticky flags:
  - Set and clear_errors in the same cycle: set wins.
  - Flags do not affect reception or the FIFO.
- Reset mid-frame: the partial byte is lost. After reset_n deasserts, the FSM must see rx_s=0 from IDLE to start a new frame.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum: IDLE, START, DATA, STOP, WAIT_IDLE.
  - Function clks_per_bit(clock_hz, baud).
  - Localparam DATA_BITS=8.
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports clock, reset_n, push, push_data, pop, head, count, full, empty.
- uart_rx_fifo contains the synchroniser, FSM, sticky flags and one sync_fifo instance.

Test Plan:
- Single byte: drive 0xA5 at 234 clocks/bit with rx_ready=0 → 1 cycle after the stop sample, rx_valid=1, rx_data=0xA5, rx_count=1. Pulse rx_ready → rx_valid=0, rx_count=0.
- Glitch rejection: low pulse of 50 clocks on an idle line → no push, FSM back in IDLE, rx_count=0, no flags set.
- Framing error: send 0x3C with the stop bit low, then hold low 1000 clocks → framing_error=1, rx_count=0, no new start while low. Line high, then 0x55 → rx_data=0x55. clear_errors → framing_error=0.
- Overrun: send bytes 0x00..0x08 (9 bytes) with rx_ready=0 → rx_count=8, overrun=1. Pops return 0x00..0x07 in order; 0x08 is lost.
- Full with simultaneous push/pop: FIFO full; assert rx_ready on the cycle of the 9th stop sample → no overrun, rx_count stays 8, last popped entry 0x00, new tail 0x08.
- Async reset mid-frame: assert reset_n=0 during bit 4 of 0xFF → all outputs at reset values immediately. After release, send 0x12 → rx_data=0x12, no flags set.
